pe_phase_solver_core: RTL and testbench
=======================================

// Module: pe_phase_solver_core
// PURPOSE
//  Parametrised phase-update processing element for the oscillator Ising solver; successor to the single-spin PE.
//  Streams coupling phases/weights from the shared spin memory LANES at a time, accumulates gradient and
//  alignment metric, updates its own phase modulo 2^PHASE_W and repeats for max_iter iterations under a start/done handshake.
// PARAMETERS
//  NUM_SPINS    64   spins in problem; must be a multiple of LANES (elaboration $error otherwise)
//  LANES        4    spins consumed per cycle
//  PHASE_W      8    phase width; full circle = 2^PHASE_W
//  COUPLE_W     4    signed coupling weight width
//  STEP_SHIFT   3    gradient step = grad >>> STEP_SHIFT (arithmetic)
//  GLOBAL_INDEX 0    this PE's own spin index; its coupling is masked
//  NOISE_BITS   4    noise amplitude width (PE_NOISE_EN only)
//  ANNEAL_PERIOD 8   iterations per noise halving (PE_NOISE_EN only)
//  LFSR_SEED    16'hACE1  LFSR reset value (PE_NOISE_EN only)
//  ACC_W = PHASE_W+COUPLE_W+$clog2(NUM_SPINS)+1 (localparam)
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   synchronous, active-high reset
//  start        in   1                   begin run; sampled only in IDLE
//  max_iter     in   16                  iterations for this run; latched on start
//  init_phase   in   PHASE_W             starting self phase; latched on start
//  rd_addr      out  $clog2(NUM_SPINS/LANES)  lane-group address to spin memory
//  rd_en        out  1                   rd_addr valid
//  rd_phase     in   LANES*PHASE_W       phases of group, valid exactly 1 cycle after rd_en
//  rd_coupling  in   LANES*COUPLE_W      signed weights J, same timing as rd_phase
//  busy         out  1                   high from start accept until done
//  done         out  1                   one-cycle pulse at end of run
//  phase_valid  out  1                   one-cycle pulse per completed iteration
//  phase_out    out  PHASE_W             current self phase (updated with phase_valid)
//  hamiltonian  out  ACC_W signed        metric of last completed iteration
//  iter_count   out  16                  iterations completed in current run
// BEHAVIOUR
//  Reset: FSM->IDLE; all outputs 0; accumulators 0; pending rd data discarded. Applies mid-run too.
//  FSM: IDLE -start&max_iter!=0-> FETCH; IDLE -start&max_iter==0-> FIN; FETCH (G=NUM_SPINS/LANES cycles,
//   rd_en=1, rd_addr=0..G-1) -> DRAIN (2 cycles) -> UPDATE (1) -> FETCH if iter_count+1<max_iter else FIN;
//   FIN (1 cycle, done=1) -> IDLE. start outside IDLE ignored.
//  Iteration latency: G+3 cycles from first rd_en to phase_valid; phase_valid asserts in UPDATE exit cycle.
//  Pipeline: rd data at k+1 -> lane terms registered k+2 -> summed into grad_acc/h_acc.
//  Per lane j (spin s=rd_addr*LANES+j): d = signed(self - phase_s) mod 2^PHASE_W, range [-2^(W-1), 2^(W-1)-1];
//   tri(d) = 2^(PHASE_W-2) - |d| (|-2^(W-1)| = 2^(W-1)); grad += J*d; h += J*tri(d).
//   J forced to 0 when s==GLOBAL_INDEX. Accumulators cleared at start of each FETCH. No overflow by sizing.
//  UPDATE: phase_out <= (self - (grad_acc >>> STEP_SHIFT)) truncated to PHASE_W (intentional wrap);
//   hamiltonian <= h_acc; iter_count++. self = phase_out; first iteration self = init_phase.
//  Coupled phases are re-read every iteration; memory may change between iterations.
//  FIN with max_iter==0: phase_out=init_phase, hamiltonian=0, iter_count=0, no phase_valid.
//  done and phase_valid of final iteration are in consecutive cycles (phase_valid first).
// CONFIGURATION
//  PE_NOISE_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), advances once per UPDATE, resets to LFSR_SEED;
//   noise = sign-extended lfsr[NOISE_BITS-1:0] >>> min(iter_count/ANNEAL_PERIOD, NOISE_BITS); added to phase in UPDATE.
//  Not defined: no LFSR, no noise; update is fully deterministic. Ports identical in both builds.
// TESTING  (PHASE_W=8, NUM_SPINS=4, LANES=2, STEP_SHIFT=0, GLOBAL_INDEX=0, noise off unless stated)
//  Reset held 3 cycles mid-FETCH -> busy/done/phase_valid/phase_out/hamiltonian/iter_count all 0, rd_en=0.
//  init 0x10, spin1 phase 0x00 J=+1, others J=0, max_iter=1 -> phase_out 0x00, hamiltonian 48, phase_valid 5 cycles after first rd_en.
//  init 0x02, spin1 phase 0xF0 J=+1, max_iter=1 -> d=18, phase_out 0xF0 (wrap), hamiltonian 46.
//  spin0 J=+7 phase 0x80 (self-masked), others J=0, max_iter=3 -> phase_out stays init, 3 phase_valid pulses, done once.
//  max_iter=0 -> done 1 cycle after start, no rd_en, no phase_valid; start pulsed during busy -> ignored, run unchanged.
//  PE_NOISE_EN, NOISE_BITS=4, all J=0, max_iter=16 -> per-iteration phase step within [-8,7], first 8 steps match golden LFSR model.

Source files
------------

// File: rtl/pe_phase_solver_core.sv
// Phase-update processing element for the oscillator Ising solver: streams LANES couplings per cycle,
// accumulates gradient/metric and rewrites its own phase. Define PE_NOISE_EN for annealed LFSR noise.
module pe_phase_solver_core #(
   parameter int NUM_SPINS = 64,
   parameter int LANES = 4,
   parameter int PHASE_W = 8,
   parameter int COUPLE_W = 4,
   parameter int STEP_SHIFT = 3,
   parameter int GLOBAL_INDEX = 0,
   parameter int NOISE_BITS = 4,
   parameter int ANNEAL_PERIOD = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int ACC_W = PHASE_W + COUPLE_W + $clog2(NUM_SPINS) + 1,
   localparam int ADDR_W = (NUM_SPINS / LANES > 1) ? $clog2(NUM_SPINS / LANES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [15:0]                   max_iter,
   input  logic [PHASE_W-1:0]            init_phase,
   output logic [ADDR_W-1:0]             rd_addr,
   output logic                          rd_en,
   input  logic [LANES*PHASE_W-1:0]      rd_phase,
   input  logic [LANES*COUPLE_W-1:0]     rd_coupling,
   output logic                          busy,
   output logic                          done,
   output logic                          phase_valid,
   output logic [PHASE_W-1:0]            phase_out,
   output logic signed [ACC_W-1:0]       hamiltonian,
   output logic [15:0]                   iter_count
);

   localparam int GROUPS = NUM_SPINS / LANES;
   localparam logic signed [PHASE_W:0] QUARTER = (PHASE_W + 1)'(2 ** (PHASE_W - 2));

   if (NUM_SPINS % LANES != 0) begin : g_bad_lanes
      $error("NUM_SPINS must be a multiple of LANES");
   end
   if (NOISE_BITS < 1 || ANNEAL_PERIOD < 1 || LFSR_SEED == 16'h0) begin : g_bad_noise
      $error("noise configuration needs NOISE_BITS>=1, ANNEAL_PERIOD>=1 and a nonzero LFSR seed");
   end

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, UPDATE, FIN} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          grp_q, grp_d;
   logic [15:0]                max_iter_q, max_iter_d;
   logic [15:0]                iter_q, iter_d;
   logic [PHASE_W-1:0]         phase_out_q, phase_out_d;
   logic signed [ACC_W-1:0]    ham_q, ham_d;
   logic                       pv_q, pv_d;
   logic                       done_q, done_d;
   logic signed [ACC_W-1:0]    grad_acc_q, grad_acc_d;
   logic signed [ACC_W-1:0]    h_acc_q, h_acc_d;
   logic                       rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0]          addr_d1_q, addr_d1_d;
   logic                       term_valid_q, term_valid_d;
   logic signed [ACC_W-1:0]    grad_term_q, grad_term_d;
   logic signed [ACC_W-1:0]    h_term_q, h_term_d;
   logic signed [PHASE_W-1:0]  noise;

   logic signed [PHASE_W-1:0]  lane_d;
   logic signed [PHASE_W:0]    lane_mag;
   logic signed [PHASE_W:0]    lane_tri;
   logic signed [COUPLE_W-1:0] lane_j;

   assign rd_en       = (state_q == FETCH);
   assign rd_addr     = rd_en ? grp_q : '0;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign phase_valid = pv_q;
   assign phase_out   = phase_out_q;
   assign hamiltonian = ham_q;
   assign iter_count  = iter_q;

   // Lane terms use the group address delayed to line up with the returning memory data.
   always_comb begin
      rd_valid_d   = rd_en;
      addr_d1_d    = rd_addr;
      term_valid_d = rd_valid_q;
      grad_term_d  = '0;
      h_term_d     = '0;
      lane_d       = '0;
      lane_mag     = '0;
      lane_tri     = '0;
      lane_j       = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_d   = phase_out_q - rd_phase[j*PHASE_W +: PHASE_W];
         lane_mag = lane_d[PHASE_W-1] ? -((PHASE_W + 1)'(lane_d)) : (PHASE_W + 1)'(lane_d);
         lane_tri = QUARTER - lane_mag;
         lane_j   = rd_coupling[j*COUPLE_W +: COUPLE_W];
         if (int'(addr_d1_q) * LANES + j == GLOBAL_INDEX) lane_j = '0;
         grad_term_d = grad_term_d + ACC_W'(lane_j) * ACC_W'(lane_d);
         h_term_d    = h_term_d + ACC_W'(lane_j) * ACC_W'(lane_tri);
      end
   end

`ifdef PE_NOISE_EN
   logic [15:0]                lfsr_q, lfsr_d;
   logic signed [NOISE_BITS-1:0] noise_raw;
   int                         noise_sh;

   // Noise amplitude halves every ANNEAL_PERIOD iterations until it is fully shifted out.
   always_comb begin
      noise_sh = int'(iter_q) / ANNEAL_PERIOD;
      if (noise_sh > NOISE_BITS) noise_sh = NOISE_BITS;
      noise_raw = signed'(lfsr_q[NOISE_BITS-1:0]) >>> noise_sh;
      noise     = PHASE_W'(noise_raw);
      lfsr_d    = lfsr_q;
      if (state_q == UPDATE) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign noise = '0;
`endif

   always_comb begin
      state_d     = state_q;
      grp_d       = grp_q;
      max_iter_d  = max_iter_q;
      iter_d      = iter_q;
      phase_out_d = phase_out_q;
      ham_d       = ham_q;
      pv_d        = 1'b0;
      done_d      = 1'b0;
      grad_acc_d  = grad_acc_q;
      h_acc_d     = h_acc_q;
      if (term_valid_q) begin
         grad_acc_d = grad_acc_q + grad_term_q;
         h_acc_d    = h_acc_q + h_term_q;
      end
      case (state_q)
         IDLE: begin
            grp_d      = '0;
            grad_acc_d = '0;
            h_acc_d    = '0;
            if (start) begin
               max_iter_d  = max_iter;
               phase_out_d = init_phase;
               ham_d       = '0;
               iter_d      = '0;
               state_d     = (max_iter == 16'd0) ? FIN : FETCH;
            end
         end
         FETCH: begin
            if (grp_q == ADDR_W'(GROUPS - 1)) begin
               grp_d   = '0;
               state_d = DRAIN;
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         DRAIN: begin
            if (grp_q == ADDR_W'(1)) begin
               grp_d   = '0;
               state_d = UPDATE;
            end else begin
               grp_d = grp_q + 1'b1;
            end
         end
         UPDATE: begin
            phase_out_d = phase_out_q - PHASE_W'(grad_acc_q >>> STEP_SHIFT) + noise;
            ham_d       = h_acc_q;
            iter_d      = iter_q + 16'd1;
            pv_d        = 1'b1;
            grad_acc_d  = '0;
            h_acc_d     = '0;
            state_d     = (17'(iter_q) + 17'd1 < 17'(max_iter_q)) ? FETCH : FIN;
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grp_q        <= '0;
         max_iter_q   <= '0;
         iter_q       <= '0;
         phase_out_q  <= '0;
         ham_q        <= '0;
         pv_q         <= 1'b0;
         done_q       <= 1'b0;
         grad_acc_q   <= '0;
         h_acc_q      <= '0;
         rd_valid_q   <= 1'b0;
         addr_d1_q    <= '0;
         term_valid_q <= 1'b0;
         grad_term_q  <= '0;
         h_term_q     <= '0;
      end else begin
         state_q      <= state_d;
         grp_q        <= grp_d;
         max_iter_q   <= max_iter_d;
         iter_q       <= iter_d;
         phase_out_q  <= phase_out_d;
         ham_q        <= ham_d;
         pv_q         <= pv_d;
         done_q       <= done_d;
         grad_acc_q   <= grad_acc_d;
         h_acc_q      <= h_acc_d;
         rd_valid_q   <= rd_valid_d;
         addr_d1_q    <= addr_d1_d;
         term_valid_q <= term_valid_d;
         grad_term_q  <= grad_term_d;
         h_term_q     <= h_term_d;
      end
   end

endmodule

// File: tb/tb_pe_phase_solver_core.sv
// Bench for pe_phase_solver_core: hand-computed vector table, reset and handshake sequences,
// and randomized runs against an iteration-level phase model.
module tb_pe_phase_solver_core;

   localparam int PW = 8;
   localparam int NS = 4;
   localparam int LN = 2;
   localparam int CW = 4;
   localparam int SS = 0;
   localparam int GI = 0;
   localparam int ACCW = PW + CW + 2 + 1;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic [15:0]            max_iter;
   logic [PW-1:0]          init_phase;
   logic [0:0]             rd_addr;
   logic                   rd_en;
   logic [LN*PW-1:0]       rd_phase;
   logic [LN*CW-1:0]       rd_coupling;
   logic                   busy;
   logic                   done;
   logic                   phase_valid;
   logic [PW-1:0]          phase_out;
   logic signed [ACCW-1:0] hamiltonian;
   logic [15:0]            iter_count;

   int total = 0;
   int bad = 0;

   logic [7:0]  mem_ph[NS];
   int          mem_j[NS];
   int          exp_ph[$];
   int          exp_h[$];
   logic [15:0] tb_lfsr;

   typedef struct packed {
      logic [7:0]         init;
      logic [15:0]        mi;
      logic [3:0][7:0]    ph;
      logic [3:0][3:0]    jw;
      logic [7:0]         exp_phase;
      logic signed [15:0] exp_ham;
      logic [7:0]         exp_pv;
   } vec_t;

   vec_t vecs[7];

   pe_phase_solver_core #(
      .NUM_SPINS(NS), .LANES(LN), .PHASE_W(PW), .COUPLE_W(CW), .STEP_SHIFT(SS), .GLOBAL_INDEX(GI)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .init_phase(init_phase),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_phase(rd_phase), .rd_coupling(rd_coupling),
      .busy(busy), .done(done), .phase_valid(phase_valid), .phase_out(phase_out),
      .hamiltonian(hamiltonian), .iter_count(iter_count)
   );

   always #5 clk = ~clk;

   // Spin memory: data one cycle after rd_en, junk otherwise so mistimed sampling shows up.
   always @(posedge clk) begin
      for (int j = 0; j < LN; j++) begin
         if (rd_en) begin
            rd_phase[j*PW +: PW]    <= mem_ph[int'(rd_addr) * LN + j];
            rd_coupling[j*CW +: CW] <= CW'(mem_j[int'(rd_addr) * LN + j]);
         end else begin
            rd_phase[j*PW +: PW]    <= PW'($urandom);
            rd_coupling[j*CW +: CW] <= CW'($urandom);
         end
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Each iteration: wrapped signed phase difference to every unmasked spin, weighted sums, phase step.
   function automatic void model_run(input int init, input int mi);
      int self_p, grad, h, d;
`ifdef PE_NOISE_EN
      int nz, sh;
`endif
      exp_ph.delete();
      exp_h.delete();
      self_p = init;
      for (int it = 0; it < mi; it++) begin
         grad = 0;
         h = 0;
         for (int s = 0; s < NS; s++) begin
            if (s != GI) begin
               d = (self_p - int'(mem_ph[s])) & 255;
               if (d >= 128) d -= 256;
               grad += mem_j[s] * d;
               h += mem_j[s] * (64 - (d < 0 ? -d : d));
            end
         end
         self_p = (self_p - (grad >>> SS)) & 255;
`ifdef PE_NOISE_EN
         nz = int'(tb_lfsr[3:0]);
         if (nz >= 8) nz -= 16;
         sh = it / 8;
         if (sh > 4) sh = 4;
         self_p = (self_p + (nz >>> sh)) & 255;
         tb_lfsr = {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
`endif
         exp_ph.push_back(self_p);
         exp_h.push_back(h);
      end
   endfunction

   task automatic applyStimulus(input logic [7:0] init, input logic [15:0] mi, input bit poke,
                                output int pvn);
      int cyc, first_rd, first_pv, last_pv, done_cyc, rd_cnt, prev_ph, step;
      model_run(int'(init), int'(mi));
      first_rd = -1; first_pv = -1; last_pv = -1; done_cyc = -1; rd_cnt = 0; pvn = 0;
      prev_ph = int'(init);
      start = 1'b1; max_iter = mi; init_phase = init;
      @(negedge clk);
      start = 1'b0; max_iter = 16'($urandom_range(1, 9)); init_phase = 8'($urandom);
      checkOutput("busy_after_start", longint'(busy), 1);
      cyc = 0;
      while (1) begin
         if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (phase_valid) begin
            if (pvn < exp_ph.size()) begin
               checkOutput("iter_phase", longint'(phase_out), longint'(exp_ph[pvn]));
               checkOutput("iter_hamiltonian", longint'(hamiltonian), longint'(exp_h[pvn]));
               checkOutput("iter_count", longint'(iter_count), longint'(pvn + 1));
            end
`ifdef PE_NOISE_EN
            step = ((int'(phase_out) - prev_ph + 128) & 255) - 128;
            prev_ph = int'(phase_out);
            if (mem_j[1] == 0 && mem_j[2] == 0 && mem_j[3] == 0)
               checkOutput("noise_step_range", longint'(step >= -8 && step <= 7), 1);
`endif
            if (first_pv < 0) first_pv = cyc;
            last_pv = cyc;
            pvn++;
         end
         if (done) begin
            done_cyc = cyc;
            checkOutput("busy_at_done", longint'(busy), 0);
            break;
         end
         if (cyc >= 500) begin
            checkOutput("run_timeout", longint'(cyc), -1);
            break;
         end
         start = (poke && (cyc == 2 || cyc == 3));
         if (start) begin
            max_iter = 16'd0;
            init_phase = 8'hAA;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checkOutput("pv_count", longint'(pvn), longint'(mi));
      checkOutput("rd_count", longint'(rd_cnt), longint'(mi) * 2);
      if (mi == 0) begin
         checkOutput("done_latency_zero_iter", longint'(done_cyc), 1);
         checkOutput("final_phase", longint'(phase_out), longint'(init));
         checkOutput("final_hamiltonian", longint'(hamiltonian), 0);
      end else begin
         checkOutput("first_iter_latency", longint'(first_pv - first_rd), 5);
         checkOutput("done_after_last_pv", longint'(done_cyc - last_pv), 1);
         checkOutput("final_phase", longint'(phase_out), longint'(exp_ph[exp_ph.size()-1]));
         checkOutput("final_hamiltonian", longint'(hamiltonian), longint'(exp_h[exp_h.size()-1]));
      end
      checkOutput("final_iter_count", longint'(iter_count), longint'(mi));
      @(negedge clk);
      checkOutput("done_single_pulse", longint'(done), 0);
   endtask

   task automatic loadMem(input vec_t v);
      for (int s = 0; s < NS; s++) begin
         mem_ph[s] = v.ph[s];
         mem_j[s] = int'(signed'(v.jw[s]));
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"}, longint'(busy), 0);
      checkOutput({tag, "_done"}, longint'(done), 0);
      checkOutput({tag, "_phase_valid"}, longint'(phase_valid), 0);
      checkOutput({tag, "_phase_out"}, longint'(phase_out), 0);
      checkOutput({tag, "_hamiltonian"}, longint'(hamiltonian), 0);
      checkOutput({tag, "_iter_count"}, longint'(iter_count), 0);
      checkOutput({tag, "_rd_en"}, longint'(rd_en), 0);
   endtask

   initial begin
      int pvn;
      vec_t rv;
      // ph/jw listed spin3..spin0; jw is 4-bit two's complement.
      vecs[0] = '{8'h10, 16'd1, {8'h00, 8'h00, 8'h00, 8'h00}, {4'h0, 4'h0, 4'h1, 4'h0}, 8'h00, 16'sd48, 8'd1};
      vecs[1] = '{8'h02, 16'd1, {8'h00, 8'h00, 8'hF0, 8'h00}, {4'h0, 4'h0, 4'h1, 4'h0}, 8'hF0, 16'sd46, 8'd1};
      vecs[2] = '{8'h40, 16'd3, {8'h00, 8'h00, 8'h00, 8'h80}, {4'h0, 4'h0, 4'h0, 4'h7}, 8'h40, 16'sd0, 8'd3};
      vecs[3] = '{8'h00, 16'd1, {8'h00, 8'h80, 8'h00, 8'h00}, {4'h0, 4'hE, 4'h0, 4'h0}, 8'h00, 16'sd128, 8'd1};
      vecs[4] = '{8'h20, 16'd1, {8'h30, 8'h00, 8'h10, 8'h00}, {4'hF, 4'h0, 4'h3, 4'h0}, 8'hE0, 16'sd96, 8'd1};
      vecs[5] = '{8'h55, 16'd0, {8'h11, 8'h22, 8'h33, 8'h44}, {4'h1, 4'h1, 4'h1, 4'h1}, 8'h55, 16'sd0, 8'd0};
      vecs[6] = '{8'h7F, 16'd2, {8'h00, 8'h00, 8'hFF, 8'h00}, {4'h0, 4'h0, 4'h8, 4'h0}, 8'h7F, 16'sd512, 8'd2};

      reset = 1'b1; start = 1'b0; max_iter = '0; init_phase = '0;
      tb_lfsr = 16'hACE1;
      for (int s = 0; s < NS; s++) begin
         mem_ph[s] = '0;
         mem_j[s] = 0;
      end
      repeat (3) @(negedge clk);
      checkIdleZero("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         loadMem(vecs[i]);
         applyStimulus(vecs[i].init, vecs[i].mi, (i == 2), pvn);
`ifndef PE_NOISE_EN
         checkOutput($sformatf("vec%0d_phase", i), longint'(phase_out), longint'(vecs[i].exp_phase));
         checkOutput($sformatf("vec%0d_ham", i), longint'(hamiltonian), longint'(vecs[i].exp_ham));
`endif
         checkOutput($sformatf("vec%0d_pv", i), longint'(pvn), longint'(vecs[i].exp_pv));
      end

      // Reset held three cycles while fetching, then a clean run must follow.
      loadMem(vecs[4]);
      start = 1'b1; max_iter = 16'd5; init_phase = 8'h33;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("midrun_fetching", longint'(rd_en), 1);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkIdleZero("midrun_reset");
      reset = 1'b0;
      tb_lfsr = 16'hACE1;
      @(negedge clk);
      checkIdleZero("after_reset");
      applyStimulus(8'h20, 16'd2, 1'b0, pvn);

      for (int r = 0; r < 10; r++) begin
         for (int s = 0; s < NS; s++) begin
            mem_ph[s] = 8'($urandom);
            mem_j[s] = int'($urandom_range(0, 15)) - 8;
         end
         rv.init = 8'($urandom);
         rv.mi = 16'($urandom_range(1, 4));
         applyStimulus(rv.init, rv.mi, ($urandom_range(0, 1) == 1), pvn);
      end

`ifdef PE_NOISE_EN
      for (int s = 0; s < NS; s++) mem_j[s] = 0;
      applyStimulus(8'h80, 16'd16, 1'b0, pvn);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
